// File: rtl/amo_pkg.sv
// Shared definitions for the AMO read-modify-write sequencer.
// Optional min/max AMOs are enabled with the AMO_MINMAX_EN macro.
package amo_pkg;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SWAP = 3'b001;
    localparam logic [2:0] F3_AND  = 3'b010;
    localparam logic [2:0] F3_OR   = 3'b011;
    localparam logic [2:0] F3_MIN  = 3'b100;
    localparam logic [2:0] F3_MAX  = 3'b101;
    localparam logic [2:0] F3_MINU = 3'b110;
    localparam logic [2:0] F3_MAXU = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_READ  = 3'd2,
        ST_RWAIT = 3'd3,
        ST_WRITE = 3'd4,
        ST_RESP  = 3'd5
    } state_e;

    // Encodings 1xx are only legal when the min/max extension is built in.
    function automatic logic funct3_illegal(input logic [2:0] f3);
        funct3_illegal = f3[2];
`ifdef AMO_MINMAX_EN
        funct3_illegal = 1'b0;
`endif
    endfunction

endpackage

// File: rtl/amo_alu.sv
// Combinational AMO combine step: new = op(old, rs2).
// Min/max operations exist only when AMO_MINMAX_EN is defined.
module amo_alu
    import amo_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] old_val,
    input  logic [DATA_W-1:0] rs2_val,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] new_val
);

    always_comb begin
        new_val = old_val;
        case (funct3)
            F3_ADD:  new_val = old_val + rs2_val;
            F3_SWAP: new_val = rs2_val;
            F3_AND:  new_val = old_val & rs2_val;
            F3_OR:   new_val = old_val | rs2_val;
`ifdef AMO_MINMAX_EN
            F3_MIN:  new_val = ($signed(old_val) < $signed(rs2_val)) ? old_val : rs2_val;
            F3_MAX:  new_val = ($signed(old_val) > $signed(rs2_val)) ? old_val : rs2_val;
            F3_MINU: new_val = (old_val < rs2_val) ? old_val : rs2_val;
            F3_MAXU: new_val = (old_val > rs2_val) ? old_val : rs2_val;
`endif
            default: new_val = old_val;
        endcase
    end

endmodule

// File: rtl/amo_rmw_sequencer.sv
// RV32A AMO read-modify-write sequencer between execute and the data-memory port.
// Build with AMO_MINMAX_EN defined to accept the min/max funct3 encodings.
module amo_rmw_sequencer
    import amo_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid and its payload stay stable until that edge.
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rs1,
    input  logic [DATA_W-1:0] req_rs2,
    input  logic [2:0]        req_funct3,
    input  logic              req_aq,
    input  logic              req_rl,
    input  logic [4:0]        req_rd,
    input  logic              st_pending,
    output logic              aq_block,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [4:0]        rsp_rd,
    output logic              rsp_err,
    output logic [2:0]        dbg_state
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   rs2_q, rs2_d;
    logic [2:0]          f3_q, f3_d;
    logic                aq_q, aq_d;
    logic [4:0]          rd_q, rd_d;
    logic [DATA_W-1:0]   old_q, old_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   alu_new;
    logic                bad_req;

    amo_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .old_val (mem_rdata),
        .rs2_val (rs2_q),
        .funct3  (f3_q),
        .new_val (alu_new)
    );

    assign bad_req = (req_rs1[1:0] != 2'b00) || funct3_illegal(req_funct3);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rs2_d   = rs2_q;
        f3_d    = f3_q;
        aq_d    = aq_q;
        rd_d    = rd_q;
        old_d   = old_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d = req_rs1;
                    rs2_d  = req_rs2;
                    f3_d   = req_funct3;
                    aq_d   = req_aq;
                    rd_d   = req_rd;
                    old_d  = '0;
                    err_d  = 1'b0;
                    if (bad_req) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (req_rl) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_DRAIN: begin
                if (!st_pending) state_d = ST_READ;
            end
            ST_READ: begin
                if (mem_gnt) state_d = ST_RWAIT;
            end
            ST_RWAIT: begin
                if (mem_rvalid) begin
                    old_d   = mem_rdata;
                    wdata_d = alu_new;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (mem_gnt) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rs2_q   <= '0;
            f3_q    <= '0;
            aq_q    <= 1'b0;
            rd_q    <= '0;
            old_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rs2_q   <= rs2_d;
            f3_q    <= f3_d;
            aq_q    <= aq_d;
            rd_q    <= rd_d;
            old_q   <= old_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs come only from state and latched fields, so they hold while stalled.
    assign req_ready = (state_q == ST_IDLE);
    assign mem_req   = (state_q == ST_READ) || (state_q == ST_WRITE);
    assign mem_we    = (state_q == ST_WRITE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = old_q;
    assign rsp_rd    = rd_q;
    assign rsp_err   = err_q;
    assign aq_block  = (state_q != ST_IDLE) && aq_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_amo_rmw_sequencer.sv
// Directed bench for amo_rmw_sequencer with a small memory model and scoreboard.
module tb_amo_rmw_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic [2:0]  req_funct3 = '0;
  logic        req_aq = 1'b0;
  logic        req_rl = 1'b0;
  logic [4:0]  req_rd = '0;
  logic        st_pending = 1'b0;
  logic        aq_block;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_err;
  logic [2:0]  dbg_state;

  amo_rmw_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_funct3(req_funct3),
    .req_aq(req_aq), .req_rl(req_rl), .req_rd(req_rd),
    .st_pending(st_pending), .aq_block(aq_block),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [37:0] exp_q[$];
  logic [63:0] wr_q[$];
  logic [37:0] rsp_e;
  logic [63:0] wr_e;
  logic [31:0] mem [0:63];
  logic        wgnt_ok = 1'b1;
  logic        rv_suppress = 1'b0;
  logic        rd_pend = 1'b0;
  logic [31:0] rd_data_pend = '0;
  int          mem_req_cnt = 0;
  int          rsp_rise_cyc = 0;
  int          acc_cyc = 0;
  logic        rsp_valid_prev = 1'b0;

  assign mem_gnt = mem_req && (!mem_we || wgnt_ok);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model plus monitor: read data returns one cycle after the read grant.
  always @(negedge clk) begin
    mem_rvalid = rd_pend && !rv_suppress;
    mem_rdata  = rd_pend ? rd_data_pend : 32'h0;
    rd_pend    = 1'b0;
    if (!rst_n) begin
      rsp_valid_prev = 1'b0;
    end else begin
      if (mem_req) mem_req_cnt++;
      if (mem_req && mem_gnt && !mem_we) begin
        rd_pend      = 1'b1;
        rd_data_pend = mem[mem_addr[7:2]];
      end
      if (mem_req && mem_gnt && mem_we) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %h data %h expected none", mem_addr, mem_wdata);
        end else begin
          wr_e = wr_q.pop_front();
          chk("mem_write", {mem_addr, mem_wdata}, wr_e);
        end
        mem[mem_addr[7:2]] = mem_wdata;
      end
      if (rsp_valid && !rsp_valid_prev) rsp_rise_cyc = cyc;
      rsp_valid_prev = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got %h expected none", {rsp_err, rsp_rd, rsp_data});
        end else begin
          rsp_e = exp_q.pop_front();
          chk("response", {26'h0, rsp_err, rsp_rd, rsp_data}, {26'h0, rsp_e});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                       input logic aq, input logic rl, input logic [4:0] rd,
                       input logic push_rsp, input logic [37:0] er,
                       input logic push_wr, input logic [63:0] ew);
    bit ok;
    @(posedge clk); #1;
    if (push_rsp) exp_q.push_back(er);
    if (push_wr) wr_q.push_back(ew);
    req_rs1 = a; req_rs2 = d; req_funct3 = f;
    req_aq = aq; req_rl = rl; req_rd = rd;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc_cyc = cyc;
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got req_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && wr_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d/%0d pending expected 0/0", name, exp_q.size(), wr_q.size());
      exp_q.delete();
      wr_q.delete();
    end
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int req_cnt_before;
    bit seen;

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4]  = 32'h0000_0003;
    mem[8]  = 32'h0000_F0F0;
    mem[12] = 32'h0000_1000;
    mem[16] = 32'hFFFF_FFFF;
    mem[20] = 32'h0000_0007;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("reset_ready", {63'h0, req_ready}, 64'h1);
    chk("reset_mem", {62'h0, mem_req, mem_we}, 64'h0);
    chk("reset_rsp", {24'h0, rsp_valid, rsp_err, rsp_rd, rsp_data}, 64'h0);
    chk("reset_aq_block", {63'h0, aq_block}, 64'h0);
    chk("reset_mem_addr", {mem_addr, mem_wdata}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // AMOADD 3 + 5.
    issue(32'h10, 32'h5, 3'b000, 1'b0, 1'b0, 5'd1, 1'b1, {1'b0, 5'd1, 32'h3}, 1'b1, {32'h10, 32'h8});
    wait_done("add");
    chk("add_latency", 64'(rsp_rise_cyc - acc_cyc), 64'd4);

    // AMOSWAP back-to-back.
    issue(32'h10, 32'hFF, 3'b001, 1'b0, 1'b0, 5'd2, 1'b1, {1'b0, 5'd2, 32'h8}, 1'b1, {32'h10, 32'hFF});
    wait_done("swap");
    chk("swap_latency", 64'(rsp_rise_cyc - acc_cyc), 64'd4);

    // AMOAND with rl drain (st_pending high for 3 sampled edges) and aq blocking.
    st_pending = 1'b1;
    issue(32'h20, 32'h0FF0, 3'b010, 1'b1, 1'b1, 5'd3, 1'b1, {1'b0, 5'd3, 32'hF0F0}, 1'b1, {32'h20, 32'h00F0});
    @(negedge clk);
    chk("drain_no_req_1", {62'h0, mem_req, aq_block}, 64'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain_no_req_2", {62'h0, mem_req, aq_block}, 64'h1);
    @(posedge clk); #1;
    st_pending = 1'b0;
    @(negedge clk);
    chk("drain_no_req_3", {62'h0, mem_req, aq_block}, 64'h1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!aq_block) begin
        chk("aq_block_held", 64'h0, 64'h1);
        break;
      end
      if (rsp_valid && rsp_ready) begin
        seen = 1'b1;
        break;
      end
    end
    chk("aq_rsp_seen", {63'h0, seen}, 64'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("aq_block_release", {62'h0, aq_block, req_ready}, 64'h1);
    wait_done("and_rl");
    chk("drain_latency", 64'(rsp_rise_cyc - acc_cyc), 64'd7);

    // Misaligned address: error, no memory access.
    req_cnt_before = mem_req_cnt;
    issue(32'h12, 32'h1, 3'b000, 1'b0, 1'b0, 5'd4, 1'b1, {1'b1, 5'd4, 32'h0}, 1'b0, 64'h0);
    wait_done("misaligned");
    chk("err_latency", 64'(rsp_rise_cyc - acc_cyc), 64'd1);
    chk("err_no_mem_req", 64'(mem_req_cnt - req_cnt_before), 64'd0);

    // AMOOR with write grant held off 4 cycles and rsp_ready held off 3 cycles.
    wgnt_ok = 1'b0;
    rsp_ready = 1'b0;
    issue(32'h30, 32'h1, 3'b011, 1'b0, 1'b0, 5'd5, 1'b1, {1'b0, 5'd5, 32'h1000}, 1'b1, {32'h30, 32'h1001});
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_we) begin
        seen = 1'b1;
        break;
      end
    end
    chk("write_reached", {63'h0, seen}, 64'h1);
    chk("write_hold_0", {mem_req, mem_we, mem_addr[29:0], mem_wdata}, {2'b11, 30'h30, 32'h1001});
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("write_hold_%0d", k), {mem_req, mem_we, mem_addr[29:0], mem_wdata},
          {2'b11, 30'h30, 32'h1001});
    end
    @(posedge clk); #1;
    wgnt_ok = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rsp_reached", {63'h0, seen}, 64'h1);
    chk("rsp_hold_0", {25'h0, rsp_valid, rsp_err, rsp_rd, rsp_data}, {25'h0, 1'b1, 1'b0, 5'd5, 32'h1000});
    for (int k = 1; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("rsp_hold_%0d", k), {25'h0, rsp_valid, rsp_err, rsp_rd, rsp_data},
          {25'h0, 1'b1, 1'b0, 5'd5, 32'h1000});
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_done("or_stall");

    // funct3=100: min when the extension is built, otherwise an error.
    req_cnt_before = mem_req_cnt;
`ifdef AMO_MINMAX_EN
    issue(32'h40, 32'h5, 3'b100, 1'b0, 1'b0, 5'd6, 1'b1, {1'b0, 5'd6, 32'hFFFF_FFFF}, 1'b1, {32'h40, 32'hFFFF_FFFF});
    wait_done("min");
    chk("min_latency", 64'(rsp_rise_cyc - acc_cyc), 64'd4);
`else
    issue(32'h40, 32'h5, 3'b100, 1'b0, 1'b0, 5'd6, 1'b1, {1'b1, 5'd6, 32'h0}, 1'b0, 64'h0);
    wait_done("min_illegal");
    chk("illegal_no_mem_req", 64'(mem_req_cnt - req_cnt_before), 64'd0);
`endif

    // Reset while waiting for read data abandons the op.
    rv_suppress = 1'b1;
    issue(32'h50, 32'h9, 3'b000, 1'b1, 1'b0, 5'd7, 1'b0, 38'h0, 1'b0, 64'h0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!mem_req) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rwait_reached", {62'h0, seen, aq_block}, 64'h3);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mem", {62'h0, mem_req, mem_we}, 64'h0);
    chk("rst_mid_state", {61'h0, req_ready, rsp_valid, aq_block}, 64'h4);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rv_suppress = 1'b0;

    // Recovery: memory at 0x50 untouched by the abandoned op.
    issue(32'h50, 32'h1, 3'b000, 1'b0, 1'b0, 5'd8, 1'b1, {1'b0, 5'd8, 32'h7}, 1'b1, {32'h50, 32'h8});
    wait_done("after_reset");
    chk("after_reset_latency", 64'(rsp_rise_cyc - acc_cyc), 64'd4);

    chk("queues_empty", 64'(exp_q.size() + wr_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
